// File: rtl/pe_array_pkg.sv
// Shared types and width helpers for the PE array sequencer.
// Holds the FSM state encoding and the clog2-derived width rules.
package pe_array_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_F,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_M  = 8;
  localparam int DEF_N  = 4;
  localparam int DEF_ND = 16;
  localparam int DEF_MT = 256;

  // width of a counter that must hold the value n itself
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // width of an index in 0..n-1, never below one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // zero means one; anything above the array limit saturates
  function automatic int cfg_clamp(input int v, input int mx);
    if (v < 1) return 1;
    if (v > mx) return mx;
    return v;
  endfunction

endpackage

// File: rtl/pe_array_seq_onehot.sv
// Registered binary-to-one-hot PE select for filter loading.
// Cleared on reset or clr; loads 1<<idx when load is high.
module pe_seq_onehot
  import pe_array_pkg::*;
#(
  parameter int N  = 32,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [N-1:0] one;
  assign one = {{(N-1){1'b0}}, 1'b1};

  // select register tracks the filter index one-for-one
  always_ff @(posedge clk) begin
    if (reset || clr) onehot <= '0;
    else if (load) onehot <= one << idx;
  end

endmodule

// File: rtl/pe_array_seq.sv
// Sequencer for a PE array: filter load, tile streaming, result drain.
// Optional perf counters when PE_ARRAY_SEQ_PERF_EN is defined.
module pe_array_seq
  import pe_array_pkg::*;
#(
  parameter int ARRAY_M    = DEF_M,
  parameter int ARRAY_N    = DEF_N,
  parameter int DATA_WIDTH = 8,
  parameter int ACCU_WIDTH = 24,
  parameter int NUM_DATA   = DEF_ND,
  parameter int MAX_TILES  = DEF_MT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [cnt_w(ARRAY_M)-1:0]     cfg_num_filter,
  input  logic [cnt_w(ARRAY_N)-1:0]     cfg_num_kernel,
  input  logic [cnt_w(MAX_TILES)-1:0]   cfg_num_tiles,
  input  logic                          fbuf_vld,
  output logic                          fbuf_req,
  input  logic                          ibuf_vld,
  output logic                          ibuf_req,
  output logic                          filter_load,
  output logic [ARRAY_M*ARRAY_N-1:0]    filter_addr,
  output logic                          input_load,
  output logic                          sys_start,
  output logic [idx_w(NUM_DATA)-1:0]    sum_timestep,
  input  logic                          acc,
  output logic                          obuf_we,
  output logic [idx_w(MAX_TILES)-1:0]   obuf_addr,
  output logic                          busy,
  output logic                          done
`ifdef PE_ARRAY_SEQ_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_run_cycles
`endif
);

  localparam int FW = cnt_w(ARRAY_M);
  localparam int KW = cnt_w(ARRAY_N);
  localparam int TW = cnt_w(MAX_TILES);
  localparam int SW = idx_w(NUM_DATA);
  localparam int OW = idx_w(MAX_TILES);
  localparam int PE = ARRAY_M * ARRAY_N;
  localparam int XW = idx_w(PE);

  if (ACCU_WIDTH < 2 * DATA_WIDTH) begin : g_width_chk
    $error("ACCU_WIDTH too narrow for a product");
  end

  state_t        state;
  logic [FW-1:0] nf, f_i, f_n;
  logic [KW-1:0] nk, k_i, k_n;
  logic [TW-1:0] nt, tile, wr, wr_n;
  logic [SW-1:0] ts;
  logic          run;

  logic idle, accept, ld, f_last, k_last;
  logic tstart, ts_last, tile_last, wr_on;
  logic oh_clr, oh_load;
  logic [XW-1:0] oh_idx;

  // handshake, strobe and next-index decode
  always_comb begin
    idle      = (state == S_IDLE);
    accept    = cfg_valid && idle;
    ld        = enable && (state == S_LOAD_F) && fbuf_vld;
    f_last    = (f_i == nf - FW'(1));
    k_last    = (k_i == nk - KW'(1));
    tstart    = enable && (state == S_STREAM) && !run && ibuf_vld;
    ts_last   = (ts == SW'(NUM_DATA - 1));
    tile_last = (tile == nt - TW'(1));
    wr_on     = acc && (state == S_STREAM || state == S_DRAIN);
    wr_n      = wr + TW'(wr_on);
    f_n       = f_last ? '0 : f_i + FW'(1);
    k_n       = f_last ? k_i + KW'(1) : k_i;
    oh_clr    = ld && f_last && k_last;
    oh_load   = accept || ld;
    oh_idx    = accept ? '0 : XW'(int'(k_n) * ARRAY_M + int'(f_n));
  end

  assign cfg_ready    = idle;
  assign busy         = !idle;
  assign fbuf_req     = ld;
  assign filter_load  = ld;
  assign ibuf_req     = tstart;
  assign input_load   = tstart;
  assign sys_start    = enable && (state == S_STREAM) && run && (ts == '0);
  assign sum_timestep = ts;
  assign obuf_we      = enable && wr_on;
  assign obuf_addr    = wr[OW-1:0];
  assign done         = enable && (state == S_DONE);

  pe_seq_onehot #(.N(PE), .IW(XW)) u_onehot (
    .clk    (clk),
    .reset  (reset),
    .clr    (oh_clr),
    .load   (oh_load),
    .idx    (oh_idx),
    .onehot (filter_addr)
  );

  // sequencer FSM; result writes counted even while frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      nf    <= FW'(1);
      nk    <= KW'(1);
      nt    <= TW'(1);
      f_i   <= '0;
      k_i   <= '0;
      tile  <= '0;
      wr    <= '0;
      ts    <= '0;
      run   <= 1'b0;
    end else begin
      if (wr_on) wr <= wr_n;
      case (state)
        S_IDLE: begin
          // a config offered while frozen is still taken
          if (accept) begin
            nf    <= FW'(cfg_clamp(int'(cfg_num_filter), ARRAY_M));
            nk    <= KW'(cfg_clamp(int'(cfg_num_kernel), ARRAY_N));
            nt    <= TW'(cfg_clamp(int'(cfg_num_tiles), MAX_TILES));
            f_i   <= '0;
            k_i   <= '0;
            tile  <= '0;
            wr    <= '0;
            ts    <= '0;
            run   <= 1'b0;
            state <= S_LOAD_F;
          end
        end
        S_LOAD_F: begin
          if (ld) begin
            f_i <= f_n;
            k_i <= k_n;
            if (f_last && k_last) state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (enable) begin
            if (!run) begin
              if (ibuf_vld) begin
                run <= 1'b1;
                ts  <= '0;
              end
            end else if (ts_last) begin
              ts   <= '0;
              run  <= 1'b0;
              tile <= tile + TW'(1);
              if (tile_last) state <= S_DRAIN;
            end else begin
              ts <= ts + SW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (enable && wr_n >= nt) state <= S_DONE;
        end
        S_DONE: begin
          if (enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PE_ARRAY_SEQ_PERF_EN
  logic stall;
  assign stall = enable &&
    ((state == S_LOAD_F && !fbuf_vld) ||
     (state == S_STREAM && !run && !ibuf_vld));

  // saturating stall and busy-cycle counters
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      perf_stall_cycles <= '0;
      perf_run_cycles   <= '0;
    end else begin
      if (stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (busy && perf_run_cycles != '1)
        perf_run_cycles <= perf_run_cycles + 32'd1;
    end
  end
`endif

endmodule
